// File: rtl/dac_wave_pkg.sv
// rtl/dac_wave_pkg.sv - shared constants, encodings and LFSR helper for the DAC waveform generator
//
// Purpose : DAC word width, waveform select codes, FSM state encodings and
//           the noise LFSR seed/taps used by dac_wave_gen.
// Ports   : none (package).
package dac_wave_pkg;

  localparam int DAC_BITS = 12;

  typedef enum logic [1:0] {
    SAW = 2'd0,
    TRI = 2'd1,
    SQR = 2'd2,
    LVL = 2'd3
  } wave_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TICK = 2'd1,
    ST_OFFER     = 2'd2
  } state_e;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bit positions 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/dac_tick_gen.sv
// rtl/dac_tick_gen.sv - sample-rate down-counter producing a single-cycle tick
//
// Purpose : counts RATE_DIV clocks between ticks; reloads RATE_DIV-1 on load
//           and on every tick.
// Ports   : i_clk   - clock (rising edge)
//           i_rst   - asynchronous active-high reset (counter = RATE_DIV-1)
//           i_load  - reload counter with RATE_DIV-1
//           i_en    - count enable
//           o_tick  - high for the cycle in which the counter is 0 while enabled
module dac_tick_gen #(
  parameter int RATE_DIV = 1000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_tick
);

  localparam int CNT_W = (RATE_DIV > 2) ? $clog2(RATE_DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(RATE_DIV - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_zero;

  assign w_zero = (r_count == '0);
  // Tick is combinational so the consumer acts on the same edge the counter reloads.
  assign o_tick = i_en && w_zero;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= RELOAD;
    end else if (i_load) begin
      r_count <= RELOAD;
    end else if (i_en) begin
      r_count <= w_zero ? RELOAD : (r_count - CNT_W'(1));
    end
  end

endmodule

// File: rtl/dac_wave_gen.sv
// rtl/dac_wave_gen.sv - periodic DAC sample generator (saw/triangle/square/level) with valid/ready output
//
// Purpose : phase-accumulator waveform source emitting one sample every
//           RATE_DIV clocks to a DAC SPI writer; flags overruns when a new
//           tick arrives before the previous sample was accepted.
// Config  : DAC_WAVE_GEN_NOISE_EN - WAVE_SEL=3 outputs LFSR noise instead of LEVEL.
// Ports   : i_system_clock  - clock (rising edge)
//           i_reset         - asynchronous active-high reset
//           i_enable        - run request
//           i_wave_sel      - 0 saw, 1 triangle, 2 square, 3 level/noise
//           i_phase_step    - phase increment per tick
//           i_level         - square high value / constant level
//           i_sample_ready  - downstream accepts sample
//           i_clr_ovr       - clear overrun pulse
//           o_sample_data   - sample word
//           o_sample_valid  - sample offered
//           o_overrun       - sticky overrun flag
//           o_active        - state machine not idle
module dac_wave_gen
  import dac_wave_pkg::*;
#(
  parameter int RATE_DIV = 1000,
  parameter int PHASE_W  = 16
) (
  input  logic                i_system_clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [1:0]          i_wave_sel,
  input  logic [PHASE_W-1:0]  i_phase_step,
  input  logic [DAC_BITS-1:0] i_level,
  input  logic                i_sample_ready,
  input  logic                i_clr_ovr,
  output logic [DAC_BITS-1:0] o_sample_data,
  output logic                o_sample_valid,
  output logic                o_overrun,
  output logic                o_active
);

  state_e              r_state;
  logic [PHASE_W-1:0]  r_phase;
  logic [DAC_BITS-1:0] r_sample_data;
  logic                r_sample_valid;
  logic                r_overrun;
  logic                r_active;

  logic                w_tick;
  logic                w_load;
  logic                w_run;
  logic                w_xfer;
  logic                w_capture;
  logic                w_drop;
  logic                w_advance;
  logic [PHASE_W-1:0]  w_phase_next;
  logic [DAC_BITS-1:0] w_tri_bits;
  logic [DAC_BITS-1:0] w_wave;

`ifdef DAC_WAVE_GEN_NOISE_EN
  logic [15:0]         r_lfsr;
`endif

  assign w_run  = (r_state != ST_IDLE);
  assign w_load = (r_state == ST_IDLE) && i_enable;

  dac_tick_gen #(
    .RATE_DIV (RATE_DIV)
  ) u_tick (
    .i_clk  (i_system_clock),
    .i_rst  (i_reset),
    .i_load (w_load),
    .i_en   (w_run),
    .o_tick (w_tick)
  );

  assign w_xfer       = r_sample_valid && i_sample_ready;
  assign w_phase_next = r_phase + i_phase_step;

  // A tick coinciding with a transfer behaves as a WAIT_TICK tick: the slot is
  // freed on the same edge, so the new sample is captured instead of dropped.
  assign w_capture = w_tick && i_enable &&
                     ((r_state == ST_WAIT_TICK) || ((r_state == ST_OFFER) && w_xfer));
  assign w_drop    = w_tick && (r_state == ST_OFFER) && !w_xfer;
  // Phase (and noise) keep running through dropped ticks, but hold once disabled.
  assign w_advance = w_capture || (w_drop && i_enable);

  assign w_tri_bits = r_phase[PHASE_W-2 -: DAC_BITS];

  always_comb begin
    w_wave = '0;
    case (wave_sel_e'(i_wave_sel))
      SAW:     w_wave = r_phase[PHASE_W-1 -: DAC_BITS];
      TRI:     w_wave = r_phase[PHASE_W-1] ? ~w_tri_bits : w_tri_bits;
      SQR:     w_wave = r_phase[PHASE_W-1] ? '0 : i_level;
`ifdef DAC_WAVE_GEN_NOISE_EN
      default: w_wave = r_lfsr[DAC_BITS-1:0];
`else
      default: w_wave = i_level;
`endif
    endcase
  end

  // Datapath: phase accumulator (and noise LFSR) advance once per honoured tick.
  always_ff @(posedge i_system_clock or posedge i_reset) begin
    if (i_reset) begin
      r_phase <= '0;
    end else if (w_advance) begin
      r_phase <= w_phase_next;
    end
  end

`ifdef DAC_WAVE_GEN_NOISE_EN
  always_ff @(posedge i_system_clock or posedge i_reset) begin
    if (i_reset) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_advance) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end
`endif

  // Control FSM with registered outputs.
  always_ff @(posedge i_system_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_sample_data  <= '0;
      r_sample_valid <= 1'b0;
      r_overrun      <= 1'b0;
      r_active       <= 1'b0;
    end else begin
      // Set has priority over clear.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (i_clr_ovr) begin
        r_overrun <= 1'b0;
      end

      if (w_capture) begin
        r_sample_data  <= w_wave;
        r_sample_valid <= 1'b1;
        r_state        <= ST_OFFER;
        r_active       <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_enable) begin
              r_state  <= ST_WAIT_TICK;
              r_active <= 1'b1;
            end
          end
          ST_WAIT_TICK: begin
            if (!i_enable) begin
              r_state  <= ST_IDLE;
              r_active <= 1'b0;
            end
          end
          ST_OFFER: begin
            // Data and valid are held until the transfer; no withdrawal.
            if (w_xfer) begin
              r_sample_valid <= 1'b0;
              if (!i_enable) begin
                r_state  <= ST_IDLE;
                r_active <= 1'b0;
              end else begin
                r_state <= ST_WAIT_TICK;
              end
            end
          end
          default: begin
            r_state        <= ST_IDLE;
            r_sample_valid <= 1'b0;
            r_active       <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_sample_data  = r_sample_data;
  assign o_sample_valid = r_sample_valid;
  assign o_overrun      = r_overrun;
  assign o_active       = r_active;

endmodule

// File: tb/tb_dac_wave_gen.sv
// tb/tb_dac_wave_gen.sv - self-checking bench for dac_wave_gen
`timescale 1ns/1ps
module tb_dac_wave_gen;
  localparam int RATE_DIV = 4;
  localparam int PHASE_W  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en = 1'b0, ready = 1'b0, clr = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [15:0] step = 16'd0;
  logic [11:0] level = 12'd0;
  logic [11:0] o_sample_data;
  logic        o_sample_valid, o_overrun, o_active;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dac_wave_gen #(.RATE_DIV(RATE_DIV), .PHASE_W(PHASE_W)) dut (
    .i_system_clock (clk),
    .i_reset        (rst),
    .i_enable       (en),
    .i_wave_sel     (sel),
    .i_phase_step   (step),
    .i_level        (level),
    .i_sample_ready (ready),
    .i_clr_ovr      (clr),
    .o_sample_data  (o_sample_data),
    .o_sample_valid (o_sample_valid),
    .o_overrun      (o_overrun),
    .o_active       (o_active)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          cyc = 0;
  int          m_start = 0;
  int          m_state = 0;   // 0 idle, 1 waiting, 2 offering
  int unsigned m_phase = 0;
  int unsigned m_data = 0;
  bit          m_valid = 0, m_ovr = 0;
  int unsigned m_lfsr = 32'hACE1;

  function automatic int unsigned lfsr_step(input int unsigned s);
    int unsigned fb;
    fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
    return ((s << 1) | fb) & 32'hFFFF;
  endfunction

  function automatic int unsigned wave_of(input int sv, input int unsigned ph,
                                          input int unsigned lvl, input int unsigned lf);
    int unsigned half, tv;
    half = 1 << (PHASE_W - 1);
    tv   = (ph / (1 << (PHASE_W - 13))) % 4096;
    case (sv)
      0: return ph / (1 << (PHASE_W - 12));
      1: return (ph < half) ? tv : 4095 - tv;
      2: return (ph < half) ? lvl : 0;
`ifdef DAC_WAVE_GEN_NOISE_EN
      default: return lf % 4096;
`else
      default: return lvl + 0 * lf;
`endif
    endcase
  endfunction

  always @(posedge clk) begin
    bit tick, xfer, cap, drop;
    cyc++;
    if (rst) begin
      m_state = 0; m_phase = 0; m_data = 0; m_valid = 0; m_ovr = 0; m_lfsr = 32'hACE1;
    end else begin
      tick = (m_state != 0) && (((cyc - m_start) % RATE_DIV) == 0);
      xfer = m_valid && ready;
      cap  = 0;
      drop = 0;
      case (m_state)
        0: if (en) begin m_state = 1; m_start = cyc; end
        1: if (!en) m_state = 0; else if (tick) cap = 1;
        default: begin
          if (xfer) begin
            if (!en) begin m_state = 0; m_valid = 0; end
            else if (tick) cap = 1;
            else begin m_state = 1; m_valid = 0; end
          end else if (tick) drop = 1;
        end
      endcase
      if (cap) begin
        m_data  = wave_of(sel, m_phase, level, m_lfsr);
        m_valid = 1;
        m_state = 2;
      end
      if (cap || (drop && en)) begin
        m_phase = (m_phase + step) % (1 << PHASE_W);
        m_lfsr  = lfsr_step(m_lfsr);
      end
      if (drop) m_ovr = 1;
      else if (clr) m_ovr = 0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    chk("valid", o_sample_valid, m_valid);
    chk("active", o_active, (m_state != 0));
    chk("overrun", o_overrun, m_ovr);
    if (m_valid) chk("data", o_sample_data, m_data);
  end

  // ---------------- directed helpers ----------------
  int cap_d[$];
  int cap_c[$];

  task automatic do_reset();
    @(negedge clk);
    en = 0;
    #2 rst = 1;
    #1;
    chk("rst_valid", o_sample_valid, 0);
    chk("rst_active", o_active, 0);
    chk("rst_overrun", o_overrun, 0);
    chk("rst_data", o_sample_data, 0);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic collect(input int n);
    int b;
    b = 0;
    cap_d.delete();
    cap_c.delete();
    while (cap_d.size() < n && b < 400) begin
      @(negedge clk);
      b++;
      if (o_sample_valid && ready) begin
        cap_d.push_back(o_sample_data);
        cap_c.push_back(cyc);
      end
    end
    chk("collect_count", cap_d.size(), n);
  endtask

  task automatic wait_valid();
    int b;
    b = 0;
    while (!o_sample_valid && b < 50) begin
      @(negedge clk);
      b++;
    end
    chk("wait_valid", o_sample_valid, 1);
  endtask

  int tri_tab[16] = '{12'h000, 12'h200, 12'h400, 12'h600, 12'h800, 12'hA00, 12'hC00, 12'hE00,
                      12'hFFF, 12'hDFF, 12'hBFF, 12'h9FF, 12'h7FF, 12'h5FF, 12'h3FF, 12'h1FF};
  int sqr_tab[4]  = '{12'hABC, 12'hABC, 12'h000, 12'h000};
`ifdef DAC_WAVE_GEN_NOISE_EN
  int lvl_tab[3]  = '{12'hCE1, 12'h9C3, 12'h387};
`else
  int lvl_tab[3]  = '{12'h5A5, 12'h5A5, 12'h5A5};
`endif

  initial begin
    rst = 1'b1;
    @(negedge clk);
    chk("init_valid", o_sample_valid, 0);
    chk("init_active", o_active, 0);
    chk("init_data", o_sample_data, 0);
    rst = 1'b0;

    // Saw, one sample every RATE_DIV clocks
    sel = 2'd0; step = 16'h1000; ready = 1; en = 1;
    collect(17);
    for (int k = 0; k < cap_d.size(); k++) begin
      chk("saw_data", cap_d[k], (k % 16) * 256);
      if (k > 0) chk("saw_period", cap_c[k] - cap_c[k-1], RATE_DIV);
    end

    // Triangle
    do_reset();
    sel = 2'd1; step = 16'h1000; ready = 1; en = 1;
    collect(17);
    for (int k = 0; k < cap_d.size(); k++) chk("tri_data", cap_d[k], tri_tab[k % 16]);

    // Square
    do_reset();
    sel = 2'd2; level = 12'hABC; step = 16'h4000; ready = 1; en = 1;
    collect(8);
    for (int k = 0; k < cap_d.size(); k++) chk("sqr_data", cap_d[k], sqr_tab[k % 4]);

    // Overrun: hold, set after one period, transfer old sample, clear
    do_reset();
    sel = 2'd0; step = 16'h1000; ready = 0; en = 1;
    wait_valid();
    chk("ovr_first_data", o_sample_data, 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("ovr_hold_valid", o_sample_valid, 1);
      chk("ovr_hold_data", o_sample_data, 0);
      chk("ovr_flag", o_overrun, (i == 4));
    end
    ready = 1;
    @(negedge clk);
    chk("ovr_xfer_valid", o_sample_valid, 0);
    chk("ovr_sticky", o_overrun, 1);
    clr = 1;
    @(negedge clk);
    clr = 0;
    chk("ovr_cleared", o_overrun, 0);

    // Enable dropped while offering with ready low
    do_reset();
    sel = 2'd0; step = 16'h1000; ready = 0; en = 1;
    wait_valid();
    en = 0;
    repeat (3) begin
      @(negedge clk);
      chk("drop_valid_held", o_sample_valid, 1);
      chk("drop_active_held", o_active, 1);
    end
    ready = 1;
    @(negedge clk);
    chk("drop_active_off", o_active, 0);
    chk("drop_valid_off", o_sample_valid, 0);

    // Reset while offering: outputs clear without a clock edge
    do_reset();
    ready = 0; en = 1;
    wait_valid();
    do_reset();

    // Level / noise select
    sel = 2'd3; level = 12'h5A5; step = 16'h1234; ready = 1; en = 1;
    collect(3);
    for (int k = 0; k < cap_d.size(); k++) chk("lvl_data", cap_d[k], lvl_tab[k]);

    // Randomised traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      en    = ($urandom % 16) != 0;
      ready = ($urandom % 3) != 0;
      clr   = ($urandom % 8) == 0;
      if (($urandom % 5) == 0) begin
        sel   = 2'($urandom % 4);
        step  = 16'($urandom);
        level = 12'($urandom % 4096);
      end
    end
    @(negedge clk);
    en = 0; ready = 1; clr = 0;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_wave_gen.md
DAC_WAVE_GEN -- requirements
Module: dac_wave_gen

Interface
REQ-001 Parameter RATE_DIV, default 1000: sample period in SYSTEM_CLOCK cycles; legal range >= 2.
REQ-002 Parameter PHASE_W, default 16: phase accumulator width; legal range >= 13.
REQ-003 SYSTEM_CLOCK  in  1  sole clock; all logic on the rising edge.
REQ-004 RESET  in  1  reset, asynchronous, active-high.
REQ-005 ENABLE  in  1  run request; high starts sample generation, low stops it.
REQ-006 WAVE_SEL  in  2  waveform select: 0 saw, 1 triangle, 2 square, 3 level/noise.
REQ-007 PHASE_STEP  in  PHASE_W  phase increment applied per tick.
REQ-008 LEVEL  in  12  square high value, and the constant value for WAVE_SEL=3.
REQ-009 SAMPLE_READY  in  1  downstream DAC SPI writer accepts the sample.
REQ-010 CLR_OVR  in  1  single-cycle pulse that clears OVERRUN.
REQ-011 SAMPLE_DATA  out  12  sample word, matching the DAC WRITE_BITS width.
REQ-012 SAMPLE_VALID  out  1  SAMPLE_DATA is offered.
REQ-013 OVERRUN  out  1  sticky flag: a tick arrived while a sample was still unaccepted.
REQ-014 ACTIVE  out  1  high whenever the state machine is not IDLE.

Function
REQ-015 States: IDLE, WAIT_TICK and OFFER, encoded as package constants.
REQ-016 IDLE: ENABLE=1 loads the tick counter with RATE_DIV-1 and moves to WAIT_TICK.
REQ-017 Tick counter: decrements each clock in WAIT_TICK and OFFER; tick when it reaches 0; reloads RATE_DIV-1 on a tick.
REQ-018 Tick period: exactly RATE_DIV clocks; first tick is RATE_DIV clocks after the clock that samples ENABLE high.
REQ-019 On a tick in WAIT_TICK:
  - register SAMPLE_DATA from the current phase;
  - set phase = phase + PHASE_STEP, modulo 2^PHASE_W;
  - enter OFFER; SAMPLE_VALID goes high on the next edge, a latency of 1 clock.
REQ-020 WAVE_SEL, PHASE_STEP and LEVEL are sampled only at a tick; changes between ticks have no effect.
REQ-021 Saw: P[PHASE_W-1:PHASE_W-12], where P is the phase.
REQ-022 Triangle: P[PHASE_W-2:PHASE_W-13], bitwise inverted when the MSB of P is 1.
REQ-023 Square: LEVEL when the MSB of P is 0, else 0x000.
REQ-024 Handshake: a transfer occurs on an edge where SAMPLE_VALID=1 and SAMPLE_READY=1; the block returns to WAIT_TICK, or to IDLE if ENABLE=0.
REQ-025 While SAMPLE_VALID=1 and unaccepted, SAMPLE_DATA and SAMPLE_VALID shall be held stable; no withdrawal.
REQ-026 Tick in OFFER:
  - the new sample is dropped;
  - the phase still advances;
  - OVERRUN is set.
REQ-027 If a transfer and a tick land on the same edge, the tick is treated as occurring in WAIT_TICK: a new sample is registered and SAMPLE_VALID stays high; no OVERRUN.
REQ-028 ENABLE=0:
  - in WAIT_TICK, go to IDLE next edge;
  - in OFFER, remain in OFFER until the transfer, then go to IDLE;
  - the phase is held, not cleared.
REQ-029 If CLR_OVR and an overrun set occur in the same cycle, set wins.

Reset
REQ-030 While RESET=1, all of the following apply immediately:
  - SAMPLE_DATA=0x000, SAMPLE_VALID=0, OVERRUN=0, ACTIVE=0;
  - state=IDLE, phase=0, counter=RATE_DIV-1, LFSR=0xACE1.
REQ-031 Reset during OFFER discards the pending sample; no transfer is reported.

Configuration
REQ-032 Macro DAC_WAVE_GEN_NOISE_EN defined:
  - WAVE_SEL=3 outputs LFSR[11:0];
  - the LFSR is 16-bit Fibonacci, taps 16,14,13,11, seed 0xACE1;
  - the LFSR advances once per tick;
  - LEVEL is ignored for WAVE_SEL=3.
REQ-033 Macro DAC_WAVE_GEN_NOISE_EN undefined: WAVE_SEL=3 outputs LEVEL, and no LFSR logic is present.

Structure
REQ-034 Package dac_wave_pkg holds:
  - DAC_BITS=12;
  - WAVE_SEL codes SAW, TRI, SQR, LVL;
  - state encodings;
  - the LFSR seed and taps.
REQ-035 Sub-module dac_tick_gen: RATE_DIV down-counter with load, enable and a single-cycle tick output; the FSM and waveform logic stay in dac_wave_gen.

Verification
REQ-036 RATE_DIV=4, saw, PHASE_STEP=0x1000, READY=1 -> SAMPLE_DATA 0x000, 0x100, ..., 0xF00, then 0x000, one sample every 4 clocks.
REQ-037 Triangle, same step -> 0x000, 0x200, ..., 0xE00, 0xFFF, 0xDFF, ..., 0x1FF, repeating.
REQ-038 Square, LEVEL=0xABC, step 0x4000 -> 0xABC, 0xABC, 0x000, 0x000, repeating.
REQ-039 READY=0, RATE_DIV=4 -> VALID held with data stable; OVERRUN=1 four clocks after VALID rises; READY=1 transfers the old sample; a CLR_OVR pulse then gives OVERRUN=0.
REQ-040 Two mid-operation cases:
  - ENABLE dropped in OFFER with READY=0 -> VALID held; after READY, ACTIVE=0 within 1 clock;
  - RESET asserted in OFFER -> VALID=0 at once, with no clock required.
REQ-041 With DAC_WAVE_GEN_NOISE_EN defined, WAVE_SEL=3 -> first samples equal the LFSR sequence from 0xACE1, masked to 12 bits; with the macro undefined -> LEVEL.
